// File: rtl/mod_edge_stream_pkg.sv
// Shared types and constants for the streaming
// Laplacian edge filter.
package mod_edge_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int KSIZE_N = 3;
  localparam int KSIZE_SET [KSIZE_N] = '{3, 5, 7};

  // Headroom over DW for the signed kernel sum:
  // 48*(2^DW-1) magnitude plus sign fits in DW+7.
  localparam int S_EXTRA = 7;

  function automatic int s_width(input int dw);
    return dw + S_EXTRA;
  endfunction

  function automatic bit ksize_legal(input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < KSIZE_N; i++) begin
      if (KSIZE_SET[i] == k) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/mod_edge_linebuf.sv
// One-row delay line: combinational read of the
// stored column, write of the new value on accept.
module mod_edge_linebuf #(
  parameter int WD    = 24,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [WD-1:0] wdata_i,
  output logic [WD-1:0] rdata_o
);

  logic [WD-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Old value is read this cycle, replaced at the edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/mod_edge_stream.sv
// Streaming KxK Laplacian edge filter with
// valid/ready pixel ports and zeroed borders.
module mod_edge_stream
  import mod_edge_stream_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CH    = 3,
  parameter int KSIZE = 3,
  parameter int MAX_W = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        width,
  input  logic [15:0]        height,
  input  logic               abs_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   out_data
);

  localparam int PW  = CH * DW;
  localparam int HF  = KSIZE / 2;
  localparam int KK  = KSIZE * KSIZE;
  localparam int SW  = s_width(DW);
  localparam int AW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam bit KOK = ksize_legal(KSIZE);
  localparam logic [SW-1:0] MAXV = SW'((1 << DW) - 1);

  state_e state_q, state_d;

  logic [15:0]   width_q, height_q;
  logic          abs_q, bad_q;
  logic [15:0]   col_q, row_q;
  logic [15:0]   ox_q, oy_q;
  logic          olast_q;
  logic          out_valid_q;
  logic [PW-1:0] out_data_q;
  logic          done_q, err_q;

  logic [PW-1:0] win_q [KSIZE][KSIZE];
  logic [PW-1:0] win_d [KSIZE][KSIZE];
  logic [PW-1:0] colv  [KSIZE];
  logic [PW-1:0] lb_rd [KSIZE-1];

  logic          geom_ok;
  logic          acc;
  logic          col_last, row_last;
  logic          ox_last, oy_last;
  logic          primed;
  logic          interior;
  logic          load_en;
  logic [PW-1:0] load_data;
  logic [PW-1:0] lap;

  logic [SW-1:0] tot, s, mag;
  logic [DW-1:0] chv;

  assign geom_ok = KOK
                && (width >= 16'(KSIZE))
                && ({16'd0, width} <= 32'(MAX_W))
                && (height >= 16'(KSIZE));

  assign in_ready = (state_q == S_RUN)
                 && (!out_valid_q || out_ready);
  assign acc      = in_ready && in_valid;

  assign col_last = (col_q == width_q - 16'd1);
  assign row_last = (row_q == height_q - 16'd1);
  assign ox_last  = (ox_q == width_q - 16'd1);
  assign oy_last  = (oy_q == height_q - 16'd1);

  // Input index has reached HF rows plus HF pixels.
  assign primed = (row_q > 16'(HF))
               || ((row_q == 16'(HF))
                   && (col_q >= 16'(HF)));

  assign interior = (ox_q >= 16'(HF))
                 && (oy_q >= 16'(HF))
                 && (({1'b0, ox_q} + 17'(HF))
                     < {1'b0, width_q})
                 && (({1'b0, oy_q} + 17'(HF))
                     < {1'b0, height_q});

  assign busy      = (state_q == S_RUN)
                  || (state_q == S_FLUSH);
  assign done      = done_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Column entering the window: new pixel on top,
  // older rows from the line-buffer chain below.
  always_comb begin
    colv[0] = in_data;
    for (int r = 1; r < KSIZE; r++) begin
      colv[r] = lb_rd[r-1];
    end
  end

  for (genvar g = 0; g < KSIZE - 1; g++) begin : g_lb
    mod_edge_linebuf #(
      .WD    (PW),
      .DEPTH (MAX_W),
      .AW    (AW)
    ) u_lb (
      .clk     (clk),
      .we_i    (acc),
      .addr_i  (col_q[AW-1:0]),
      .wdata_i (colv[g]),
      .rdata_o (lb_rd[g])
    );
  end

  // Window after this cycle's shift.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][KSIZE-1] = colv[r];
    end
  end

  // Shift register window, moves only on accept.
  always_ff @(posedge clk) begin
    if (acc) win_q <= win_d;
  end

  // Per-channel K^2*centre minus full window sum,
  // then clamp or magnitude-saturate.
  always_comb begin
    lap = '0;
    tot = '0;
    s   = '0;
    mag = '0;
    chv = '0;
    for (int ch = 0; ch < CH; ch++) begin
      tot = '0;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) begin
          tot = tot + SW'(win_d[r][c][ch*DW +: DW]);
        end
      end
      s = SW'(KK) * SW'(win_d[HF][HF][ch*DW +: DW])
        - tot;
      mag = s[SW-1] ? (~s + SW'(1)) : s;
      if (s[SW-1] && !abs_q) chv = '0;
      else if (mag > MAXV)   chv = '1;
      else                   chv = mag[DW-1:0];
      lap[ch*DW +: DW] = chv;
    end
  end

  // Output register load source and enable.
  always_comb begin
    load_en   = 1'b0;
    load_data = '0;
    unique case (1'b1)
      (state_q == S_RUN): begin
        load_en   = acc && primed;
        load_data = interior ? lap : '0;
      end
      (state_q == S_FLUSH): begin
        load_en = (!out_valid_q || out_ready)
               && !olast_q;
      end
      default: ;
    endcase
  end

  // Frame control next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = geom_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (acc && col_last && row_last)
          state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (out_valid_q && out_ready && olast_q)
          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Geometry latch, counters, output and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q     <= '0;
      height_q    <= '0;
      abs_q       <= 1'b0;
      bad_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      olast_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == S_IDLE && start) begin
        width_q  <= width;
        height_q <= height;
        abs_q    <= abs_en;
        bad_q    <= !geom_ok;
        col_q    <= '0;
        row_q    <= '0;
        ox_q     <= '0;
        oy_q     <= '0;
        olast_q  <= 1'b0;
      end
      if (state_q == S_DONE) begin
        done_q <= 1'b1;
        err_q  <= bad_q;
      end
      if (acc) begin
        col_q <= col_last ? 16'd0 : col_q + 16'd1;
        if (col_last)
          row_q <= row_last ? 16'd0 : row_q + 16'd1;
      end
      if (load_en) begin
        out_valid_q <= 1'b1;
        out_data_q  <= load_data;
        ox_q        <= ox_last ? 16'd0 : ox_q + 16'd1;
        if (ox_last)
          oy_q <= oy_last ? 16'd0 : oy_q + 16'd1;
        olast_q     <= ox_last && oy_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
